life_ctrl: RTL and testbench

Sequencer for a row of `life_col4` columns (4 cells each). It accepts one command at a time from the host side and drives the shared `enable`, `row` and `val` buses plus a one-hot per-column write strobe. Supported commands: load a single cell, clear the whole array, run N generations, or single-step one generation. It sits between the display/UI logic and the cell array, and guarantees that writes and evolution never overlap.

---
 rtl/life_ctrl.sv | 152 +++++++++++++++
 tb/tb_life_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_ctrl.sv
`default_nettype none
// ============================================================================
//  life_ctrl
//  Command sequencer for a row of 4-cell life columns: cell write, array
//  clear, bounded/free run and single step, never overlapping write/evolve.
//  Revision: 1.0
// ============================================================================
module life_ctrl #(
  parameter int NCOLS = 4,
  parameter int GEN_W = 8,
  parameter int CW    = $clog2(NCOLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CW-1:0]     cmd_col,
  input  logic [1:0]        cmd_row,
  input  logic              cmd_val,
  input  logic [GEN_W-1:0]  cmd_gens,
  input  logic              stop,
  output logic [NCOLS-1:0]  col_write_enb,
  output logic [1:0]        row,
  output logic              val,
  output logic              enable,
  output logic [GEN_W-1:0]  gen_count,
  output logic              done
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam int         IW       = CW + 2;
  localparam logic [IW-1:0] LAST_CELL = IW'(4 * NCOLS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  state_t            state;
  logic              ready_q;
  logic [IW-1:0]     cell_idx;
  logic [IW-1:0]     cell_nxt;
  logic [GEN_W-1:0]  run_cnt;
  logic [GEN_W-1:0]  run_nxt;
  logic [GEN_W-1:0]  gens_q;

  // Out-of-range columns decode to no strobe at all.
  function automatic logic [NCOLS-1:0] col_onehot(input logic [CW-1:0] c);
    col_onehot = '0;
    for (int i = 0; i < NCOLS; i++)
      if (c == CW'(i)) col_onehot[i] = 1'b1;
  endfunction

  assign cell_nxt  = cell_idx + IW'(1);
  assign run_nxt   = run_cnt + GEN_W'(1);
  // Ready is masked by reset so the first accept lands on the edge after release.
  assign cmd_ready = ready_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ready_q       <= 1'b1;
      cell_idx      <= '0;
      run_cnt       <= '0;
      gens_q        <= '0;
      col_write_enb <= '0;
      row           <= 2'd0;
      val           <= 1'b0;
      enable        <= 1'b0;
      gen_count     <= '0;
      done          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (ready_q && cmd_valid) begin
            ready_q <= 1'b0;
            case (cmd_op)
              OP_WRITE: begin
                state         <= S_WRITE;
                col_write_enb <= col_onehot(cmd_col);
                row           <= cmd_row;
                val           <= cmd_val;
              end
              OP_CLEAR: begin
                state         <= S_CLEAR;
                cell_idx      <= '0;
                col_write_enb <= col_onehot('0);
                row           <= 2'd0;
                val           <= 1'b0;
                gen_count     <= '0;
              end
              OP_RUN: begin
                state   <= S_RUN;
                run_cnt <= '0;
                gens_q  <= cmd_gens;
                enable  <= 1'b1;
              end
              default: begin
                state  <= S_STEP;
                enable <= 1'b1;
              end
            endcase
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_WRITE: begin
          col_write_enb <= '0;
          done          <= 1'b1;
          state         <= S_IDLE;
        end
        S_CLEAR: begin
          if (cell_idx == LAST_CELL) begin
            col_write_enb <= '0;
            done          <= 1'b1;
            state         <= S_IDLE;
          end else begin
            cell_idx      <= cell_nxt;
            col_write_enb <= col_onehot(cell_nxt[IW-1:2]);
            row           <= cell_nxt[1:0];
          end
        end
        S_RUN: begin
          // The cycle in which stop is seen was enabled and still counts.
          gen_count <= gen_count + GEN_W'(1);
          run_cnt   <= run_nxt;
          if (stop || (gens_q != '0 && run_nxt == gens_q)) begin
            enable <= 1'b0;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_STEP: begin
          gen_count <= gen_count + GEN_W'(1);
          enable    <= 1'b0;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_life_ctrl
//  Directed self-checking bench for life_ctrl (NCOLS=4, GEN_W=8).
//  Revision: 1.0
// ============================================================================
module tb_life_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_col;
  logic [1:0] cmd_row;
  logic       cmd_val;
  logic [7:0] cmd_gens;
  logic       stop;
  logic [3:0] col_write_enb;
  logic [1:0] row;
  logic       val;
  logic       enable;
  logic [7:0] gen_count;
  logic       done;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_gen = 8'd0;

  life_ctrl #(.NCOLS(4), .GEN_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_val(cmd_val),
    .cmd_gens(cmd_gens), .stop(stop), .col_write_enb(col_write_enb),
    .row(row), .val(val), .enable(enable), .gen_count(gen_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, presents one command for the accepting edge, returns in cycle T+1.
  task automatic issue(input logic [1:0] op, input logic [1:0] c, input logic [1:0] r,
                       input logic v, input logic [7:0] g);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL issue_ready_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_col = c; cmd_row = r; cmd_val = v; cmd_gens = g;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_col = 2'd0; cmd_row = 2'd0; cmd_val = 1'b0; cmd_gens = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_col = 2'd1; cmd_row = 2'd1;
    cmd_val = 1'b1; cmd_gens = 8'd0; stop = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({col_write_enb, row, val, enable, gen_count, done, cmd_ready} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs: strobe=%b row=%0d val=%b en=%b gen=%0d done=%b rdy=%b required all 0",
               col_write_enb, row, val, enable, gen_count, done, cmd_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (col_write_enb !== 4'b0010 || row !== 2'd1 || val !== 1'b1) begin
      failures++;
      $display("FAIL first_accept: strobe=%b row=%0d val=%b required 0010 1 1", col_write_enb, row, val);
    end
    tick();
    checks++;
    if (done !== 1'b1 || col_write_enb !== 4'b0000 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_done: done=%b strobe=%b rdy=%b required 1 0000 0", done, col_write_enb, cmd_ready);
    end
    tick();
  endtask

  task automatic test_write();
    issue(2'b00, 2'd2, 2'd3, 1'b1, 8'd0);
    checks++;
    if (col_write_enb !== 4'b0100 || row !== 2'd3 || val !== 1'b1 || enable !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_strobe: strobe=%b row=%0d val=%b en=%b rdy=%b required 0100 3 1 0 0",
               col_write_enb, row, val, enable, cmd_ready);
    end
    tick();
    checks++;
    if (done !== 1'b1 || col_write_enb !== 4'b0000 || row !== 2'd3 || val !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_done: done=%b strobe=%b row=%0d val=%b rdy=%b required 1 0000 3 1 0",
               done, col_write_enb, row, val, cmd_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_after: done=%b rdy=%b required 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_step();
    for (int k = 0; k < 3; k++) begin
      issue(2'b11, 2'd0, 2'd0, 1'b0, 8'd0);
      checks++;
      if (enable !== 1'b1 || col_write_enb !== 4'b0000) begin
        failures++;
        $display("FAIL step_enable[%0d]: en=%b strobe=%b required 1 0000", k, enable, col_write_enb);
      end
      tick();
      exp_gen = exp_gen + 8'd1;
      checks++;
      if (enable !== 1'b0 || done !== 1'b1 || gen_count !== exp_gen) begin
        failures++;
        $display("FAIL step_done[%0d]: en=%b done=%b gen=%0d required 0 1 %0d", k, enable, done, gen_count, exp_gen);
      end
    end
  endtask

  task automatic test_clear();
    logic [3:0] exp_strobe;
    issue(2'b01, 2'd0, 2'd0, 1'b0, 8'd0);
    exp_gen = 8'd0;
    for (int i = 0; i < 16; i++) begin
      exp_strobe = 4'b0001 << (i / 4);
      checks++;
      if (col_write_enb !== exp_strobe || row !== 2'(i % 4) || val !== 1'b0 || enable !== 1'b0 ||
          gen_count !== 8'd0 || done !== 1'b0) begin
        failures++;
        $display("FAIL clear_cell[%0d]: strobe=%b row=%0d val=%b en=%b gen=%0d done=%b required %b %0d 0 0 0 0",
                 i, col_write_enb, row, val, enable, gen_count, done, exp_strobe, i % 4);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || col_write_enb !== 4'b0000) begin
      failures++;
      $display("FAIL clear_done: done=%b strobe=%b required 1 0000", done, col_write_enb);
    end
  endtask

  task automatic test_run_bounded();
    int en_cycles = 0;
    int done_cycles = 0;
    issue(2'b10, 2'd0, 2'd0, 1'b0, 8'd5);
    for (int i = 0; i < 12; i++) begin
      if (enable === 1'b1) en_cycles++;
      if (done === 1'b1) done_cycles++;
      if (enable === 1'b1 && col_write_enb !== 4'b0000) begin
        checks++; failures++;
        $display("FAIL run_overlap: strobe=%b with enable required 0000", col_write_enb);
      end
      tick();
    end
    exp_gen = exp_gen + 8'd5;
    checks++;
    if (en_cycles != 5 || done_cycles != 1 || gen_count !== exp_gen) begin
      failures++;
      $display("FAIL run_bounded: en_cycles=%0d done_cycles=%0d gen=%0d required 5 1 %0d",
               en_cycles, done_cycles, gen_count, exp_gen);
    end
  endtask

  task automatic test_run_stop();
    int en_cycles = 0;
    issue(2'b10, 2'd0, 2'd0, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) begin
      if (enable === 1'b1) en_cycles++;
      if (i == 6) stop = 1'b1;
      else tick();
    end
    tick();
    stop = 1'b0;
    exp_gen = exp_gen + 8'd7;
    checks++;
    if (en_cycles != 7 || enable !== 1'b0 || done !== 1'b1 || gen_count !== exp_gen) begin
      failures++;
      $display("FAIL run_stop: en_cycles=%0d en=%b done=%b gen=%0d required 7 0 1 %0d",
               en_cycles, enable, done, gen_count, exp_gen);
    end
    tick();
    stop = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (enable !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || gen_count !== exp_gen) begin
      failures++;
      $display("FAIL idle_stop: en=%b done=%b rdy=%b gen=%0d required 0 0 1 %0d",
               enable, done, cmd_ready, gen_count, exp_gen);
    end
    stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    int done_cycles = 0;
    // stop coincides with the final generation of a 2-generation run
    issue(2'b10, 2'd0, 2'd0, 1'b0, 8'd2);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) done_cycles++;
      tick();
    end
    exp_gen = exp_gen + 8'd2;
    checks++;
    if (done_cycles != 1 || gen_count !== exp_gen) begin
      failures++;
      $display("FAIL stop_on_final: done_cycles=%0d gen=%0d required 1 %0d", done_cycles, gen_count, exp_gen);
    end
    // early stop in the first enabled cycle of a 3-generation run
    issue(2'b10, 2'd0, 2'd0, 1'b0, 8'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_gen = exp_gen + 8'd1;
    checks++;
    if (enable !== 1'b0 || done !== 1'b1 || gen_count !== exp_gen) begin
      failures++;
      $display("FAIL early_stop: en=%b done=%b gen=%0d required 0 1 %0d", enable, done, gen_count, exp_gen);
    end
    // write issued as soon as ready returns
    issue(2'b00, 2'd3, 2'd0, 1'b1, 8'd0);
    checks++;
    if (col_write_enb !== 4'b1000 || row !== 2'd0 || val !== 1'b1) begin
      failures++;
      $display("FAIL b2b_write: strobe=%b row=%0d val=%b required 1000 0 1", col_write_enb, row, val);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_clear();
    int done_cycles = 0;
    issue(2'b01, 2'd0, 2'd0, 1'b0, 8'd0);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({col_write_enb, row, val, enable, gen_count, done, cmd_ready} !== 18'd0) begin
      failures++;
      $display("FAIL reset_mid_clear: strobe=%b row=%0d val=%b en=%b gen=%0d done=%b rdy=%b required all 0",
               col_write_enb, row, val, enable, gen_count, done, cmd_ready);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) done_cycles++;
      tick();
    end
    checks++;
    if (done_cycles != 0 || cmd_ready !== 1'b1 || gen_count !== 8'd0 || col_write_enb !== 4'b0000) begin
      failures++;
      $display("FAIL after_mid_reset: done_cycles=%0d rdy=%b gen=%0d strobe=%b required 0 1 0 0000",
               done_cycles, cmd_ready, gen_count, col_write_enb);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_step();
    test_clear();
    test_step();
    test_run_bounded();
    test_run_stop();
    test_back_to_back();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
